// File: rtl/sram_access_seq_pkg.sv
// Shared types and default timing for the cartridge SRAM access sequencer.
package sram_access_pkg;
   typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
   typedef enum logic {REQ_SNES, REQ_MCU} req_t;
   localparam int RD_WAIT_DEF = 3;
   localparam int WR_WAIT_DEF = 3;
endpackage

// File: rtl/sram_access_seq_slot.sv
// One-deep request latch. A request arriving this cycle is visible on the
// outputs immediately so an idle sequencer can start it without a bubble.
module sram_req_slot (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_set,
   input  logic [23:0] i_addr,
   input  logic [7:0]  i_data,
   input  logic        i_is_write,
   input  logic        i_grant,
   output logic        o_valid,
   output logic [23:0] o_addr,
   output logic [7:0]  o_data,
   output logic        o_is_write
);
   logic        r_valid;
   logic [23:0] r_addr;
   logic [7:0]  r_data;
   logic        r_is_write;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_is_write <= 1'b0;
      end else begin
         if (i_set) begin
            r_addr     <= i_addr;
            r_data     <= i_data;
            r_is_write <= i_is_write;
         end
         // A grant consumes whatever the outputs currently show, including a same-cycle set.
         if (i_grant)
            r_valid <= 1'b0;
         else if (i_set)
            r_valid <= 1'b1;
      end
   end

   assign o_valid    = r_valid | i_set;
   assign o_addr     = i_set ? i_addr     : r_addr;
   assign o_data     = i_set ? i_data     : r_data;
   assign o_is_write = i_set ? i_is_write : r_is_write;
endmodule

// File: rtl/sram_access_seq.sv
// Arbitrates SNES and MCU requests onto an asynchronous SRAM and runs timed
// read/write strobe sequences; SNES writes are allowed only into SaveRAM.
module sram_access_seq #(
   parameter int RD_WAIT = sram_access_pkg::RD_WAIT_DEF,
   parameter int WR_WAIT = sram_access_pkg::WR_WAIT_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SNES_RD_START,
   input  logic        SNES_WR_START,
   input  logic [23:0] ROM_ADDR,
   input  logic        ROM_HIT,
   input  logic        IS_SAVERAM,
   input  logic [7:0]  SNES_DIN,
   output logic [7:0]  SNES_DOUT,
   output logic        SNES_DOUT_VALID,
   input  logic        MCU_RRQ,
   input  logic        MCU_WRQ,
   input  logic [23:0] MCU_ADDR,
   input  logic [7:0]  MCU_DOUT,
   output logic [7:0]  MCU_DIN,
   output logic        MCU_RDY,
   output logic [23:0] RAM_ADDR,
   output logic [7:0]  RAM_DQ_OUT,
   output logic        RAM_DQ_OE,
   input  logic [7:0]  RAM_DQ_IN,
   output logic        RAM_CE_N,
   output logic        RAM_OE_N,
   output logic        RAM_WE_N
);
   import sram_access_pkg::*;

   localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

   state_t           r_state;
   req_t             r_req;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ce_n, r_oe_n, r_we_n, r_dq_oe;
   logic [23:0]      r_addr;
   logic [7:0]       r_dq_out, r_snes_dout, r_mcu_din;
   logic             r_snes_vld, r_mcu_rdy;

   logic             w_snes_rd, w_snes_set, w_mcu_set;
   logic             w_snes_valid, w_snes_is_write, w_mcu_valid, w_mcu_is_write;
   logic [23:0]      w_snes_addr, w_mcu_addr, w_win_addr;
   logic [7:0]       w_snes_data, w_mcu_data, w_win_data;
   logic             w_grant_snes, w_grant_mcu, w_win_write;

   // SNES writes outside SaveRAM never reach the slot; that is the ROM write protection.
   assign w_snes_rd  = SNES_RD_START & ROM_HIT;
   assign w_snes_set = w_snes_rd | (SNES_WR_START & ROM_HIT & IS_SAVERAM);
   assign w_mcu_set  = r_mcu_rdy & (MCU_RRQ | MCU_WRQ);

   sram_req_slot u_snes_slot (
      .i_clk(CLK), .i_rst(RST), .i_set(w_snes_set), .i_addr(ROM_ADDR),
      .i_data(SNES_DIN), .i_is_write(~w_snes_rd), .i_grant(w_grant_snes),
      .o_valid(w_snes_valid), .o_addr(w_snes_addr), .o_data(w_snes_data),
      .o_is_write(w_snes_is_write)
   );

   sram_req_slot u_mcu_slot (
      .i_clk(CLK), .i_rst(RST), .i_set(w_mcu_set), .i_addr(MCU_ADDR),
      .i_data(MCU_DOUT), .i_is_write(~MCU_RRQ), .i_grant(w_grant_mcu),
      .o_valid(w_mcu_valid), .o_addr(w_mcu_addr), .o_data(w_mcu_data),
      .o_is_write(w_mcu_is_write)
   );

   assign w_grant_snes = (r_state == IDLE) & w_snes_valid;
   assign w_grant_mcu  = (r_state == IDLE) & ~w_snes_valid & w_mcu_valid;
   assign w_win_addr   = w_grant_snes ? w_snes_addr     : w_mcu_addr;
   assign w_win_data   = w_grant_snes ? w_snes_data     : w_mcu_data;
   assign w_win_write  = w_grant_snes ? w_snes_is_write : w_mcu_is_write;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_req       <= REQ_SNES;
         r_cnt       <= '0;
         r_ce_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_dq_oe     <= 1'b0;
         r_addr      <= '0;
         r_dq_out    <= '0;
         r_snes_dout <= '0;
         r_snes_vld  <= 1'b0;
         r_mcu_din   <= '0;
         r_mcu_rdy   <= 1'b1;
      end else begin
         r_snes_vld <= 1'b0;
         if (w_mcu_set)
            r_mcu_rdy <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_snes || w_grant_mcu) begin
                  r_req  <= w_grant_snes ? REQ_SNES : REQ_MCU;
                  r_addr <= w_win_addr;
                  r_ce_n <= 1'b0;
                  if (w_win_write) begin
                     r_dq_out <= w_win_data;
                     r_dq_oe  <= 1'b1;
                     r_state  <= WR_SETUP;
                  end else begin
                     r_oe_n  <= 1'b0;
                     r_cnt   <= RD_LOAD;
                     r_state <= RD;
                  end
               end
            end
            RD: begin
               if (r_cnt == '0) begin
                  r_ce_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_state <= IDLE;
                  if (r_req == REQ_SNES) begin
                     r_snes_dout <= RAM_DQ_IN;
                     r_snes_vld  <= 1'b1;
                  end else begin
                     r_mcu_din <= RAM_DQ_IN;
                     r_mcu_rdy <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            WR_SETUP: begin
               r_we_n  <= 1'b0;
               r_cnt   <= WR_LOAD;
               r_state <= WR_PULSE;
            end
            WR_PULSE: begin
               if (r_cnt == '0) begin
                  r_we_n  <= 1'b1;
                  r_ce_n  <= 1'b1;
                  r_state <= WR_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            WR_HOLD: begin
               r_dq_oe <= 1'b0;
               r_state <= IDLE;
               if (r_req == REQ_MCU)
                  r_mcu_rdy <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign RAM_ADDR        = r_addr;
   assign RAM_DQ_OUT      = r_dq_out;
   assign RAM_DQ_OE       = r_dq_oe;
   assign RAM_CE_N        = r_ce_n;
   assign RAM_OE_N        = r_oe_n;
   assign RAM_WE_N        = r_we_n;
   assign SNES_DOUT       = r_snes_dout;
   assign SNES_DOUT_VALID = r_snes_vld;
   assign MCU_DIN         = r_mcu_din;
   assign MCU_RDY         = r_mcu_rdy;
endmodule

// File: tb/tb_sram_access_seq.sv
// Self-checking bench for sram_access_seq with an SRAM model and a reference memory.
module tb_sram_access_seq;
   localparam int RDW = 3;
   localparam int WRW = 3;

   logic        CLK = 1'b0, RST = 1'b0;
   logic        SNES_RD_START = 0, SNES_WR_START = 0, ROM_HIT = 0, IS_SAVERAM = 0;
   logic [23:0] ROM_ADDR = '0, MCU_ADDR = '0;
   logic [7:0]  SNES_DIN = '0, MCU_DOUT = '0, RAM_DQ_IN = '0;
   logic        MCU_RRQ = 0, MCU_WRQ = 0;
   logic [7:0]  SNES_DOUT, MCU_DIN, RAM_DQ_OUT;
   logic        SNES_DOUT_VALID, MCU_RDY, RAM_DQ_OE, RAM_CE_N, RAM_OE_N, RAM_WE_N;
   logic [23:0] RAM_ADDR;

   int n_tests = 0, n_fail = 0;

   logic [7:0] sram    [logic [23:0]];
   logic [7:0] ref_mem [logic [23:0]];

   always #5 CLK = ~CLK;

   sram_access_seq #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
      .CLK(CLK), .RST(RST), .SNES_RD_START(SNES_RD_START), .SNES_WR_START(SNES_WR_START),
      .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_SAVERAM(IS_SAVERAM), .SNES_DIN(SNES_DIN),
      .SNES_DOUT(SNES_DOUT), .SNES_DOUT_VALID(SNES_DOUT_VALID), .MCU_RRQ(MCU_RRQ),
      .MCU_WRQ(MCU_WRQ), .MCU_ADDR(MCU_ADDR), .MCU_DOUT(MCU_DOUT), .MCU_DIN(MCU_DIN),
      .MCU_RDY(MCU_RDY), .RAM_ADDR(RAM_ADDR), .RAM_DQ_OUT(RAM_DQ_OUT), .RAM_DQ_OE(RAM_DQ_OE),
      .RAM_DQ_IN(RAM_DQ_IN), .RAM_CE_N(RAM_CE_N), .RAM_OE_N(RAM_OE_N), .RAM_WE_N(RAM_WE_N)
   );

   function automatic logic [7:0] sram_rd(input logic [23:0] a);
      return sram.exists(a) ? sram[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [23:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // Asynchronous SRAM: drives data while selected and output-enabled, stores while WE is low.
   always @(negedge CLK)
      RAM_DQ_IN = (!RAM_CE_N && !RAM_OE_N) ? sram_rd(RAM_ADDR) : 8'h00;
   always @(posedge CLK)
      if (!RAM_CE_N && !RAM_WE_N && RAM_DQ_OE) sram[RAM_ADDR] = RAM_DQ_OUT;

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic clear_pulses();
      SNES_RD_START = 0; SNES_WR_START = 0; MCU_RRQ = 0; MCU_WRQ = 0;
      ROM_HIT = 0; IS_SAVERAM = 0;
   endtask

   task automatic test_reset();
      #2 RST = 1;
      tick(); tick();
      n_tests++;
      if ({RAM_CE_N, RAM_OE_N, RAM_WE_N, RAM_DQ_OE, SNES_DOUT_VALID, MCU_RDY} !== 6'b111001) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 111001",
            {RAM_CE_N, RAM_OE_N, RAM_WE_N, RAM_DQ_OE, SNES_DOUT_VALID, MCU_RDY});
      end
      n_tests++;
      if ({RAM_ADDR, RAM_DQ_OUT, SNES_DOUT, MCU_DIN} !== 48'h0) begin
         n_fail++; $display("FAIL reset_data: got %h want 0", {RAM_ADDR, RAM_DQ_OUT, SNES_DOUT, MCU_DIN});
      end
      RST = 0;
      tick();
   endtask

   task automatic test_snes_read();
      logic act;
      sram[24'hC01234] = 8'h5A; ref_mem[24'hC01234] = 8'h5A;
      ROM_ADDR = 24'hC01234; ROM_HIT = 1; SNES_RD_START = 1;
      for (int c = 1; c <= RDW + 2; c++) begin
         tick(); clear_pulses();
         act = (c <= RDW);
         n_tests++;
         if ({RAM_CE_N, RAM_OE_N} !== (act ? 2'b00 : 2'b11)) begin
            n_fail++; $display("FAIL rd_strobe c%0d: got %b act=%b", c, {RAM_CE_N, RAM_OE_N}, act);
         end
         n_tests++;
         if (SNES_DOUT_VALID !== (c == RDW + 1)) begin
            n_fail++; $display("FAIL rd_valid c%0d: got %b", c, SNES_DOUT_VALID);
         end
         if (act) begin
            n_tests++;
            if (RAM_ADDR !== 24'hC01234) begin
               n_fail++; $display("FAIL rd_addr c%0d: got %h want c01234", c, RAM_ADDR);
            end
         end
         if (c == RDW + 1) begin
            n_tests++;
            if (SNES_DOUT !== 8'h5A) begin
               n_fail++; $display("FAIL rd_data: got %h want 5a", SNES_DOUT);
            end
         end
      end
   endtask

   task automatic test_snes_write();
      ROM_ADDR = 24'hFF0010; ROM_HIT = 1; IS_SAVERAM = 1; SNES_DIN = 8'hA5; SNES_WR_START = 1;
      ref_mem[24'hFF0010] = 8'hA5;
      for (int c = 1; c <= WRW + 4; c++) begin
         tick(); clear_pulses();
         n_tests++;
         if (RAM_WE_N !== !(c >= 2 && c <= WRW + 1)) begin
            n_fail++; $display("FAIL wr_we c%0d: got %b", c, RAM_WE_N);
         end
         n_tests++;
         if (RAM_DQ_OE !== (c <= WRW + 2)) begin
            n_fail++; $display("FAIL wr_dqoe c%0d: got %b", c, RAM_DQ_OE);
         end
         n_tests++;
         if (RAM_CE_N !== !(c <= WRW + 1)) begin
            n_fail++; $display("FAIL wr_ce c%0d: got %b", c, RAM_CE_N);
         end
      end
      n_tests++;
      if (sram_rd(24'hFF0010) !== 8'hA5) begin
         n_fail++; $display("FAIL wr_mem: got %h want a5", sram_rd(24'hFF0010));
      end
   endtask

   task automatic test_rom_protect();
      int lows;
      lows = 0;
      sram[24'hC00000] = 8'h77; ref_mem[24'hC00000] = 8'h77;
      ROM_ADDR = 24'hC00000; ROM_HIT = 1; IS_SAVERAM = 0; SNES_DIN = 8'h3C; SNES_WR_START = 1;
      for (int c = 1; c <= 8; c++) begin
         tick(); clear_pulses();
         if (RAM_CE_N !== 1'b1 || RAM_WE_N !== 1'b1) lows++;
      end
      n_tests++;
      if (lows !== 0) begin
         n_fail++; $display("FAIL protect_strobe: got %0d active cycles want 0", lows);
      end
      n_tests++;
      if (sram_rd(24'hC00000) !== 8'h77) begin
         n_fail++; $display("FAIL protect_mem: got %h want 77", sram_rd(24'hC00000));
      end
   endtask

   task automatic test_mcu_then_snes();
      logic [7:0] d;
      int rs;
      d = 8'($urandom);
      rs = WRW + 4;
      sram[24'hC00200] = d; ref_mem[24'hC00200] = d;
      MCU_ADDR = 24'hC00100; MCU_DOUT = 8'h11; MCU_WRQ = 1; ref_mem[24'hC00100] = 8'h11;
      for (int c = 1; c <= rs + RDW + 1; c++) begin
         tick(); clear_pulses();
         if (c == 2) begin
            ROM_ADDR = 24'hC00200; ROM_HIT = 1; SNES_RD_START = 1;
         end
         n_tests++;
         if (MCU_RDY !== (c >= WRW + 3)) begin
            n_fail++; $display("FAIL mix_rdy c%0d: got %b", c, MCU_RDY);
         end
         n_tests++;
         if (RAM_OE_N !== !(c >= rs && c < rs + RDW)) begin
            n_fail++; $display("FAIL mix_rd_start c%0d: oe_n got %b", c, RAM_OE_N);
         end
         if (c == rs + RDW) begin
            n_tests++;
            if (SNES_DOUT_VALID !== 1'b1 || SNES_DOUT !== d) begin
               n_fail++; $display("FAIL mix_rd_data: got %b/%h want 1/%h", SNES_DOUT_VALID, SNES_DOUT, d);
            end
         end
      end
      n_tests++;
      if (sram_rd(24'hC00100) !== 8'h11) begin
         n_fail++; $display("FAIL mix_wr_mem: got %h want 11", sram_rd(24'hC00100));
      end
   endtask

   task automatic test_mcu_vs_snes();
      logic [23:0] sa, ma;
      logic [7:0]  sd, md;
      sa = 24'hC10000 | 24'($urandom_range(0, 255));
      ma = 24'hD20000 | 24'($urandom_range(0, 255));
      sd = 8'($urandom); md = 8'($urandom);
      sram[sa] = sd; ref_mem[sa] = sd; sram[ma] = md; ref_mem[ma] = md;
      ROM_ADDR = sa; ROM_HIT = 1; SNES_RD_START = 1; MCU_ADDR = ma; MCU_RRQ = 1;
      for (int c = 1; c <= 2 * RDW + 3; c++) begin
         tick(); clear_pulses();
         if (c <= RDW) begin
            n_tests++;
            if (RAM_OE_N !== 1'b0 || RAM_ADDR !== sa) begin
               n_fail++; $display("FAIL prio_snes c%0d: oe_n=%b addr=%h want 0/%h", c, RAM_OE_N, RAM_ADDR, sa);
            end
         end
         if (c > RDW + 1 && c <= 2 * RDW + 1) begin
            n_tests++;
            if (RAM_OE_N !== 1'b0 || RAM_ADDR !== ma) begin
               n_fail++; $display("FAIL prio_mcu c%0d: oe_n=%b addr=%h want 0/%h", c, RAM_OE_N, RAM_ADDR, ma);
            end
         end
         if (c == RDW + 1) begin
            n_tests++;
            if (SNES_DOUT_VALID !== 1'b1 || SNES_DOUT !== sd) begin
               n_fail++; $display("FAIL prio_snes_data: got %b/%h want 1/%h", SNES_DOUT_VALID, SNES_DOUT, sd);
            end
         end
         n_tests++;
         if (MCU_RDY !== (c >= 2 * RDW + 2)) begin
            n_fail++; $display("FAIL prio_rdy c%0d: got %b", c, MCU_RDY);
         end
         if (c == 2 * RDW + 2) begin
            n_tests++;
            if (MCU_DIN !== md) begin
               n_fail++; $display("FAIL prio_mcu_data: got %h want %h", MCU_DIN, md);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      logic [23:0] a;
      logic [7:0]  old;
      int lows;
      a = 24'hE00000 | 24'($urandom_range(0, 4095));
      old = 8'h42; sram[a] = old; ref_mem[a] = old;
      MCU_ADDR = a; MCU_DOUT = 8'hBD; MCU_WRQ = 1;
      tick(); clear_pulses();
      ROM_ADDR = a; ROM_HIT = 1; SNES_RD_START = 1;
      tick(); clear_pulses();
      RST = 1;
      #1;
      n_tests++;
      if ({RAM_CE_N, RAM_OE_N, RAM_WE_N, RAM_DQ_OE} !== 4'b1110) begin
         n_fail++; $display("FAIL rst_strobes: got %b want 1110", {RAM_CE_N, RAM_OE_N, RAM_WE_N, RAM_DQ_OE});
      end
      n_tests++;
      if (MCU_RDY !== 1'b1) begin
         n_fail++; $display("FAIL rst_rdy: got %b want 1", MCU_RDY);
      end
      #2 RST = 0;
      lows = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (RAM_CE_N !== 1'b1 || SNES_DOUT_VALID !== 1'b0) lows++;
      end
      n_tests++;
      if (lows !== 0) begin
         n_fail++; $display("FAIL rst_replay: got %0d active cycles want 0", lows);
      end
      n_tests++;
      if (sram_rd(a) !== old) begin
         n_fail++; $display("FAIL rst_mem: got %h want %h", sram_rd(a), old);
      end
   endtask

   task automatic test_random();
      logic [23:0] pool [8];
      logic [23:0] a;
      logic [7:0]  d;
      int kind, seen, lows;
      for (int i = 0; i < 8; i++) pool[i] = 24'hF00000 | 24'(i * 24'h111);
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 5);
         a = pool[$urandom_range(0, 7)];
         d = 8'($urandom);
         seen = 0; lows = 0;
         case (kind)
            0, 1: begin
               ROM_ADDR = a; ROM_HIT = (kind == 0); SNES_RD_START = 1;
            end
            2, 3: begin
               ROM_ADDR = a; ROM_HIT = 1; IS_SAVERAM = (kind == 2); SNES_DIN = d; SNES_WR_START = 1;
               if (kind == 2) ref_mem[a] = d;
            end
            4: begin
               MCU_ADDR = a; MCU_RRQ = 1;
            end
            default: begin
               MCU_ADDR = a; MCU_DOUT = d; MCU_WRQ = 1; ref_mem[a] = d;
            end
         endcase
         for (int c = 1; c <= 20 && seen == 0; c++) begin
            tick(); clear_pulses();
            if (RAM_CE_N !== 1'b1) lows++;
            if (kind == 0 && SNES_DOUT_VALID === 1'b1) seen = c;
            if (kind >= 4 && MCU_RDY === 1'b1) seen = c;
            if ((kind == 1 || kind == 3) && c == 8) seen = c;
            if (kind == 2 && c == WRW + 3) seen = c;
         end
         n_tests++;
         case (kind)
            0: if (seen != RDW + 1 || SNES_DOUT !== ref_rd(a)) begin
                  n_fail++; $display("FAIL rnd_snes_rd %0d: lat=%0d data=%h want lat=%0d data=%h",
                     n, seen, SNES_DOUT, RDW + 1, ref_rd(a));
               end
            1, 3: if (lows != 0) begin
                  n_fail++; $display("FAIL rnd_ignored %0d kind%0d: got %0d active cycles want 0", n, kind, lows);
               end
            2: if (RAM_CE_N !== 1'b1 || RAM_DQ_OE !== 1'b0 || sram_rd(a) !== ref_rd(a)) begin
                  n_fail++; $display("FAIL rnd_snes_wr %0d: mem=%h want %h", n, sram_rd(a), ref_rd(a));
               end
            4: if (seen != RDW + 1 || MCU_DIN !== ref_rd(a)) begin
                  n_fail++; $display("FAIL rnd_mcu_rd %0d: lat=%0d data=%h want lat=%0d data=%h",
                     n, seen, MCU_DIN, RDW + 1, ref_rd(a));
               end
            default: if (seen != WRW + 3) begin
                  n_fail++; $display("FAIL rnd_mcu_wr %0d: lat=%0d want %0d", n, seen, WRW + 3);
               end
         endcase
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (sram_rd(pool[i]) !== ref_rd(pool[i])) begin
            n_fail++; $display("FAIL rnd_final_mem %h: got %h want %h", pool[i], sram_rd(pool[i]), ref_rd(pool[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_snes_read();
      test_snes_write();
      test_rom_protect();
      test_mcu_then_snes();
      test_mcu_vs_snes();
      test_mcu_vs_snes();
      test_reset_mid_write();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
